// File: rtl/fp32_convert_unit.sv
// fp32_convert_unit: iterative RV32F converter for FCVT.S.W/WU (int->fp) and FCVT.W/WU.S (fp->int).
// One request is processed at a time: latch, unpack, shift a few bits per cycle, round once, then
// hold the response until the consumer takes it.
module fp32_convert_unit #(
    parameter int SHIFT_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_cmd,
    input  logic        req_unsigned,
    input  logic [2:0]  req_rm,
    input  logic [31:0] req_src,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic [4:0]  resp_fflags
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_NORM   = 3'd2,
        S_SHIFT  = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [4:0] FLAG_NV = 5'b10000;
    localparam logic [4:0] FLAG_NX = 5'b00001;

    // Round-up decision on the magnitude; modes 5-7 truncate like RTZ.
    function automatic logic rnd_inc(input logic [2:0] rm, input logic neg,
                                     input logic lsb, input logic g, input logic s);
        logic inc;
        case (rm)
            3'd0:    inc = g & (s | lsb);
            3'd2:    inc = (g | s) & neg;
            3'd3:    inc = (g | s) & ~neg;
            3'd4:    inc = g;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

    state_t      state_q, state_d;
    logic        cmd_q, cmd_d;
    logic        uns_q, uns_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] src_q, src_d;
    logic        sign_q, sign_d;
    logic [31:0] work_q, work_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        shl_q, shl_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_result_q, resp_result_d;
    logic [4:0]  resp_fflags_q, resp_fflags_d;

    // Next-state and datapath computation for every FSM state.
    always_comb begin : next_logic
        logic [31:0] mag;
        logic [31:0] w;
        logic        g;
        logic        s;
        logic [7:0]  e;
        logic [7:0]  c;
        logic [7:0]  fexp;
        logic [22:0] frac;
        logic [31:0] pos_sat;
        logic [31:0] neg_sat;
        logic        inc;
        logic        carry;
        logic [23:0] mant_r;
        logic [32:0] sum;
        logic [32:0] lim;
        logic        inexact;

        state_d       = state_q;
        cmd_d         = cmd_q;
        uns_d         = uns_q;
        rm_d          = rm_q;
        src_d         = src_q;
        sign_d        = sign_q;
        work_d        = work_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        exp_d         = exp_q;
        cnt_d         = cnt_q;
        shl_d         = shl_q;
        resp_result_d = resp_result_q;
        resp_fflags_d = resp_fflags_q;
        mag     = 32'd0;
        w       = work_q;
        g       = guard_q;
        s       = sticky_q;
        e       = exp_q;
        c       = cnt_q;
        fexp    = src_q[30:23];
        frac    = src_q[22:0];
        pos_sat = uns_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        neg_sat = uns_q ? 32'h0000_0000 : 32'h8000_0000;
        inc     = 1'b0;
        carry   = 1'b0;
        mant_r  = 24'd0;
        sum     = 33'd0;
        lim     = 33'd0;
        inexact = guard_q | sticky_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    cmd_d   = req_cmd;
                    uns_d   = req_unsigned;
                    rm_d    = req_rm;
                    src_d   = req_src;
                    state_d = S_UNPACK;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_UNPACK: begin
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                shl_d    = 1'b0;
                if (!cmd_q) begin
                    sign_d = ~uns_q & src_q[31];
                    mag    = (~uns_q & src_q[31]) ? (32'd0 - src_q) : src_q;
                    work_d = mag;
                    exp_d  = 8'd158;
                    if (mag == 32'd0) begin
                        resp_result_d = 32'd0;
                        resp_fflags_d = 5'd0;
                        state_d       = S_DONE;
                    end else if (mag[31]) begin
                        state_d = S_ROUND;
                    end else begin
                        state_d = S_NORM;
                    end
                end else begin
                    sign_d = src_q[31];
                    if (fexp == 8'hFF && frac != 23'd0) begin
                        resp_result_d = pos_sat;
                        resp_fflags_d = FLAG_NV;
                        state_d       = S_DONE;
                    end else if (fexp >= 8'd159) begin
                        // Infinity or |x| >= 2^32: out of range for every integer form.
                        resp_result_d = src_q[31] ? neg_sat : pos_sat;
                        resp_fflags_d = FLAG_NV;
                        state_d       = S_DONE;
                    end else if (fexp == 8'd0 && frac == 23'd0) begin
                        resp_result_d = 32'd0;
                        resp_fflags_d = 5'd0;
                        state_d       = S_DONE;
                    end else if (fexp < 8'd126) begin
                        // |x| < 0.5 (denormals included): only the sticky bit survives.
                        work_d   = 32'd0;
                        sticky_d = 1'b1;
                        state_d  = S_ROUND;
                    end else if (fexp < 8'd150) begin
                        work_d  = {8'd0, 1'b1, frac};
                        cnt_d   = 8'd150 - fexp;
                        state_d = S_SHIFT;
                    end else if (fexp == 8'd150) begin
                        work_d  = {8'd0, 1'b1, frac};
                        state_d = S_ROUND;
                    end else begin
                        work_d  = {8'd0, 1'b1, frac};
                        cnt_d   = fexp - 8'd150;
                        shl_d   = 1'b1;
                        state_d = S_SHIFT;
                    end
                end
            end

            S_NORM: begin
                for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
                    if (!w[31]) begin
                        w = {w[30:0], 1'b0};
                        e = e - 8'd1;
                    end
                end
                work_d  = w;
                exp_d   = e;
                state_d = w[31] ? S_ROUND : S_NORM;
            end

            S_SHIFT: begin
                for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
                    if (c != 8'd0) begin
                        if (shl_q) begin
                            w = {w[30:0], 1'b0};
                        end else begin
                            s = s | g;
                            g = w[0];
                            w = {1'b0, w[31:1]};
                        end
                        c = c - 8'd1;
                    end
                end
                work_d   = w;
                guard_d  = g;
                sticky_d = s;
                cnt_d    = c;
                state_d  = (c == 8'd0) ? S_ROUND : S_SHIFT;
            end

            S_ROUND: begin
                if (!cmd_q) begin
                    inexact         = work_q[7] | (|work_q[6:0]);
                    inc             = rnd_inc(rm_q, sign_q, work_q[8], work_q[7], |work_q[6:0]);
                    {carry, mant_r} = {1'b0, work_q[31:8]} + {24'd0, inc};
                    resp_result_d   = {sign_q, exp_q + {7'd0, carry},
                                       carry ? mant_r[23:1] : mant_r[22:0]};
                    resp_fflags_d   = inexact ? FLAG_NX : 5'd0;
                end else begin
                    inc = rnd_inc(rm_q, sign_q, work_q[0], guard_q, sticky_q);
                    sum = {1'b0, work_q} + {32'd0, inc};
                    if (!sign_q) begin
                        lim = uns_q ? 33'h0_FFFF_FFFF : 33'h0_7FFF_FFFF;
                        if (sum > lim) begin
                            resp_result_d = lim[31:0];
                            resp_fflags_d = FLAG_NV;
                        end else begin
                            resp_result_d = sum[31:0];
                            resp_fflags_d = inexact ? FLAG_NX : 5'd0;
                        end
                    end else if (uns_q) begin
                        // Negative values are invalid unless they round to zero.
                        resp_result_d = 32'd0;
                        if (sum != 33'd0) begin
                            resp_fflags_d = FLAG_NV;
                        end else begin
                            resp_fflags_d = inexact ? FLAG_NX : 5'd0;
                        end
                    end else begin
                        if (sum > 33'h0_8000_0000) begin
                            resp_result_d = 32'h8000_0000;
                            resp_fflags_d = FLAG_NV;
                        end else begin
                            resp_result_d = 32'd0 - sum[31:0];
                            resp_fflags_d = inexact ? FLAG_NX : 5'd0;
                        end
                    end
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_DONE);
    end

    // State, datapath and registered handshake outputs; reset aborts any operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cmd_q         <= 1'b0;
            uns_q         <= 1'b0;
            rm_q          <= 3'd0;
            src_q         <= 32'd0;
            sign_q        <= 1'b0;
            work_q        <= 32'd0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            exp_q         <= 8'd0;
            cnt_q         <= 8'd0;
            shl_q         <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_result_q <= 32'd0;
            resp_fflags_q <= 5'd0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            uns_q         <= uns_d;
            rm_q          <= rm_d;
            src_q         <= src_d;
            sign_q        <= sign_d;
            work_q        <= work_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            exp_q         <= exp_d;
            cnt_q         <= cnt_d;
            shl_q         <= shl_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_fflags_q <= resp_fflags_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_fflags = resp_fflags_q;

endmodule

// File: tb/tb_fp32_convert_unit.sv
// Directed-vector bench for fp32_convert_unit: table of conversions plus handshake/reset sequences.
module tb_fp32_convert_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_cmd;
    logic        req_unsigned;
    logic [2:0]  req_rm;
    logic [31:0] req_src;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [4:0]  resp_fflags;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [4:0] NV = 5'b10000;
    localparam logic [4:0] NX = 5'b00001;

    fp32_convert_unit #(.SHIFT_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_unsigned(req_unsigned), .req_rm(req_rm), .req_src(req_src),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_fflags(resp_fflags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cmd;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] src;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request and wait for its accepting edge; returns the cycles spent waiting.
    task automatic issue(input logic cmd, input logic uns, input logic [2:0] rm,
                         input logic [31:0] src, output int waited);
        req_cmd      = cmd;
        req_unsigned = uns;
        req_rm       = rm;
        req_src      = src;
        req_valid    = 1'b1;
        waited       = 0;
        while (!req_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: req_ready stayed 0");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_src   = $urandom;
        req_rm    = 3'($urandom_range(0, 7));
        req_cmd   = ~cmd;
    endtask

    // Count negedges from accept until resp_valid is seen.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL resp_timeout: resp_valid stayed 0");
        end
    endtask

    task automatic take_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waited;
        int lat;
        logic seen;
        string nm;

        //           cmd   uns   rm    src            result         flags  lat
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'hBF800000, 5'd0, 34};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 32'h4F800000, NX,   3};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 32'h01000001, 32'h4B800000, NX,   10};
        vecs[3]  = '{1'b0, 1'b0, 3'd3, 32'h01000001, 32'h4B800001, NX,   10};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 32'h00000000, 5'd0, 2};
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 32'h40200000, 32'h00000002, NX,   25};
        vecs[6]  = '{1'b1, 1'b0, 3'd4, 32'h40200000, 32'h00000003, NX,   0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h40200000, 32'h00000002, NX,   0};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'hC0200000, 32'hFFFFFFFD, NX,   0};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 32'h7FC00000, 32'h7FFFFFFF, NV,   2};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 32'hCF000000, 32'h80000000, 5'd0, 11};
        vecs[11] = '{1'b1, 1'b1, 3'd0, 32'hBF800000, 32'h00000000, NV,   0};
        vecs[12] = '{1'b1, 1'b1, 3'd0, 32'hBE800000, 32'h00000000, NX,   3};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 32'h80000000, 32'hCF000000, 5'd0, 3};
        vecs[14] = '{1'b1, 1'b1, 3'd0, 32'h4F800000, 32'hFFFFFFFF, NV,   2};
        vecs[15] = '{1'b1, 1'b0, 3'd0, 32'h4F000000, 32'h7FFFFFFF, NV,   0};
        vecs[16] = '{1'b1, 1'b1, 3'd0, 32'h4F000000, 32'h80000000, 5'd0, 0};
        vecs[17] = '{1'b1, 1'b0, 3'd0, 32'hFF800000, 32'h80000000, NV,   2};
        vecs[18] = '{1'b1, 1'b0, 3'd7, 32'h3FC00000, 32'h00000001, NX,   0};
        vecs[19] = '{1'b1, 1'b0, 3'd0, 32'h3FC00000, 32'h00000002, NX,   0};
        vecs[20] = '{1'b1, 1'b0, 3'd0, 32'h00000000, 32'h00000000, 5'd0, 2};
        vecs[21] = '{1'b1, 1'b0, 3'd3, 32'h00000001, 32'h00000001, NX,   0};
        vecs[22] = '{1'b1, 1'b0, 3'd2, 32'h80000001, 32'hFFFFFFFF, NX,   0};
        vecs[23] = '{1'b0, 1'b0, 3'd2, 32'hFEFFFFFF, 32'hCB800001, NX,   0};
        vecs[24] = '{1'b0, 1'b1, 3'd1, 32'h00000003, 32'h40400000, 5'd0, 33};
        vecs[25] = '{1'b1, 1'b0, 3'd0, 32'h4B000001, 32'h00800001, 5'd0, 3};
        vecs[26] = '{1'b1, 1'b1, 3'd0, 32'h4F7FFFFF, 32'hFFFFFF00, 5'd0, 0};

        rst          = 1'b0;
        req_valid    = 1'b0;
        req_cmd      = 1'b0;
        req_unsigned = 1'b0;
        req_rm       = 3'd0;
        req_src      = 32'd0;
        resp_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_result", resp_result, 32'd0);
        check("reset_fflags", {27'd0, resp_fflags}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Table of conversions.
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            issue(vecs[i].cmd, vecs[i].uns, vecs[i].rm, vecs[i].src, waited);
            wait_resp(lat);
            $sformat(nm, "vec%0d_result", i);
            check(nm, resp_result, vecs[i].res);
            $sformat(nm, "vec%0d_fflags", i);
            check(nm, {27'd0, resp_fflags}, {27'd0, vecs[i].fl});
            if (vecs[i].lat != 0) begin
                $sformat(nm, "vec%0d_latency", i);
                check(nm, lat, vecs[i].lat);
            end
            take_resp();
        end

        // Back-pressure: response held stable while resp_ready is low.
        @(negedge clk);
        issue(1'b1, 1'b0, 3'd0, 32'h7FC00000, waited);
        wait_resp(lat);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_result", resp_result, 32'h7FFFFFFF);
            check("hold_fflags", {27'd0, resp_fflags}, {27'd0, NV});
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        take_resp();
        @(negedge clk);
        check("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        check("b2b_resp_valid_low", {31'd0, resp_valid}, 32'd0);
        issue(1'b0, 1'b0, 3'd0, 32'h00000007, waited);
        check("b2b_accept_wait", waited, 0);
        wait_resp(lat);
        check("b2b_result", resp_result, 32'h40E00000);
        check("b2b_fflags", {27'd0, resp_fflags}, 32'd0);
        take_resp();

        // Reset in the middle of normalisation aborts without a response.
        @(negedge clk);
        issue(1'b0, 1'b0, 3'd0, 32'h00000001, waited);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("abort_no_response", {31'd0, seen}, 32'd0);
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 1'b0, 3'd0, 32'h00000005, waited);
        wait_resp(lat);
        check("after_abort_result", resp_result, 32'h40A00000);
        check("after_abort_fflags", {27'd0, resp_fflags}, 32'd0);
        take_resp();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
